ad9361_rx_burst_ctrl: RTL and testbench
=======================================

# ad9361_rx_burst_ctrl

Burst-capture sequencer for the AD9361 RX CMOS interface in pulse-mode ENSM control. It drives the interface's `enable`/`txnrx` control pins, gates the sample stream into the downstream capture buffer, and counts received port-0 samples. Accepted requests take the form of a burst length. Each burst is bracketed by two ENSM enable pulses (ALERT→RX, RX→ALERT) with guard and settle intervals. The block sits between the host register file and the AD9361 interface, on the interface's processing clock (`USE_EXT_CLOCK = 1` build).

## Interface
- `STARTUP_DELAY`, 16: cycles after reset before the first request may be accepted.
- `ENABLE_CYCLES`, 4: width of each `enable` pulse, and width of the post-burst guard gap.
- `SETTLE_CYCLES`, 8: cycles between the end of the RX-entry pulse and the first gated sample.
- `LEN_WIDTH`, 16: width of the burst length and the sample counter.
- `TIMEOUT_CYCLES`, 65535: maximum length of the CAPTURE state, in cycles.
- `clk` in 1: processing clock, the same clock that samples the interface outputs.
- `rst` in 1: reset; asynchronous, active-high.
- `req_valid` in 1: burst request.
- `req_ready` out 1: the request is accepted when `req_valid & req_ready`.
- `req_len` in LEN_WIDTH: number of samples to capture; sampled on acceptance.
- `abort` in 1: terminates the active burst early.
- `sample_valid` in 1: `valid_0` from the interface.
- `enable` out 1: drives the AD9361 ENABLE pin.
- `txnrx` out 1: drives the AD9361 TXNRX pin; constant 0 (RX only).
- `capture_en` out 1: gates the interface samples into the capture buffer.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: result of the last burst. 00 = ok, 01 = aborted, 10 = timeout. Valid from the `done` pulse until the next acceptance.
- `sample_count` out LEN_WIDTH: number of samples counted in the current or last burst.

## Operation
- States:
  - STARTUP → IDLE after STARTUP_DELAY cycles.
  - IDLE → EN_ON on acceptance, when `req_len` ≠ 0.
  - EN_ON → SETTLE after ENABLE_CYCLES.
  - SETTLE → CAPTURE after SETTLE_CYCLES.
  - CAPTURE → EN_OFF on completion, abort, or timeout.
  - EN_OFF → GUARD after ENABLE_CYCLES.
  - GUARD → IDLE after ENABLE_CYCLES.
- Moore outputs, all registered:
  - `enable` = EN_ON or EN_OFF.
  - `capture_en` = CAPTURE.
  - `req_ready` = IDLE.
  - `busy` = not IDLE.
- A single phase counter is reloaded on every state entry.
- `sample_count` clears on acceptance. In CAPTURE it increments on each `sample_valid`.
- Completion: a `sample_valid` that brings the count to `req_len` ends CAPTURE. That sample is counted, and the next state is EN_OFF.
- Abort:
  - In IDLE or STARTUP: ignored.
  - In EN_ON or SETTLE: latched. CAPTURE then exits after exactly one cycle with `sample_count` = 0 (a `sample_valid` in that cycle is ignored), and status = aborted.
  - In CAPTURE: exits the next cycle.
  - In EN_OFF or GUARD: ignored.
- Priority when events coincide in the same cycle: completion > abort > timeout.
- Timeout: the CAPTURE cycle counter reaches TIMEOUT_CYCLES → status = timeout. The count achieved so far is retained.
- `req_len` = 0: accepted, no `enable` pulse. `done` pulses the cycle after acceptance with status ok; the state stays IDLE.
- `done` pulses on the GUARD→IDLE transition.
- Counter arithmetic is unsigned LEN_WIDTH and never wraps: maximum `req_len` = 2^LEN_WIDTH − 1.

## Timing
- Reset values:
  - state = STARTUP.
  - `enable`, `txnrx`, `capture_en`, `req_ready`, `done` = 0.
  - `busy` = 1.
  - `status` = 00.
  - `sample_count` = 0.
- Reset mid-burst: all outputs return to reset values immediately (async assert). Deassertion is synchronous to `clk`, and the full STARTUP_DELAY is re-run.
- Acceptance at cycle T, with E = ENABLE_CYCLES and S = SETTLE_CYCLES:
  - `enable` = 1 for cycles T+1 … T+E.
  - SETTLE for cycles T+E+1 … T+E+S.
  - `capture_en` = 1 from cycle T+E+S+1.
- Completing sample at cycle C:
  - `capture_en` = 0 at C+1.
  - `enable` = 1 for C+1 … C+E.
  - GUARD for C+E+1 … C+2E.
  - `done` = 1 and `req_ready` = 1 at C+2E+1.
- First `req_ready` occurs at cycle STARTUP_DELAY after reset release.
- `req_ready` is not asserted during a burst; back-to-back bursts are therefore separated by at least ENABLE_CYCLES low cycles on `enable`.

## Structure
- Shared package `ad9361_pkg`:
  - State enum.
  - Status encodings: STATUS_OK, STATUS_ABORT, STATUS_TIMEOUT.
- One sub-module, `ad9361_phase_timer`: a loadable down-counter that reports expiry. It provides the STARTUP, EN_ON, SETTLE, EN_OFF and GUARD intervals.
- The CAPTURE timeout counter and the sample counter live in the top level.

## Test plan
- Reset release, `req_valid` held high → `req_ready` first goes high at cycle 16; `enable` stays 0 until then.
- `req_len` = 5, with `sample_valid` every other cycle →
  - `enable` high for 4 cycles.
  - 8 settle cycles.
  - `capture_en` drops the cycle after the 5th sample.
  - Second 4-cycle `enable` pulse.
  - `done` 4 cycles after that pulse, with `sample_count` = 5 and status = 00.
- `req_len` = 10; `abort` asserted after 3 samples → exit the next cycle, `sample_count` = 3, status = 01, and the EN_OFF pulse is still emitted.
- `abort` during SETTLE → exactly one CAPTURE cycle, `sample_count` = 0, status = 01.
- TIMEOUT_CYCLES = 20 and no `sample_valid` → CAPTURE lasts 20 cycles, status = 10.
- `req_len` = 0 → `done` the next cycle, `enable` never asserted. Separately: `sample_valid` and `abort` in the same cycle as the final sample → status = 00.
- Async `rst` pulse during CAPTURE → `enable` and `capture_en` go to 0 within the same cycle, and STARTUP repeats.

Source files
------------

// File: rtl/ad9361_pkg.sv
// Shared state and status encodings for the AD9361 RX burst-capture controller.
package ad9361_pkg;

    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_STARTUP = 3'd0;
    localparam state_t ST_IDLE    = 3'd1;
    localparam state_t ST_EN_ON   = 3'd2;
    localparam state_t ST_SETTLE  = 3'd3;
    localparam state_t ST_CAPTURE = 3'd4;
    localparam state_t ST_EN_OFF  = 3'd5;
    localparam state_t ST_GUARD   = 3'd6;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ABORT   = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

endpackage

// File: rtl/ad9361_phase_timer.sv
// Loadable down-counter timing the fixed-length phases; expiry means the current cycle is the last one.
module ad9361_phase_timer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired_c
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= WIDTH'(RESET_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign expired_c = (cnt == '0);

endmodule

// File: rtl/ad9361_rx_burst_ctrl.sv
// Pulse-mode ENSM burst sequencer: brackets each RX capture with ENABLE pulses and counts port-0 samples.
module ad9361_rx_burst_ctrl
    import ad9361_pkg::*;
#(
    parameter int unsigned STARTUP_DELAY  = 16,
    parameter int unsigned ENABLE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic                 abort,
    input  logic                 sample_valid,
    output logic                 enable,
    output logic                 txnrx,
    output logic                 capture_en,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [LEN_WIDTH-1:0] sample_count
);

    localparam int unsigned PH_MAX0 = (STARTUP_DELAY > ENABLE_CYCLES) ? STARTUP_DELAY : ENABLE_CYCLES;
    localparam int unsigned PH_MAX  = (PH_MAX0 > SETTLE_CYCLES) ? PH_MAX0 : SETTLE_CYCLES;
    localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state, state_nxt;
    logic                 ph_load_c, ph_expired_c;
    logic [PH_W-1:0]      ph_val_c;
    logic [LEN_WIDTH-1:0] len_q, len_nxt;
    logic [LEN_WIDTH-1:0] count_nxt;
    logic [TO_W-1:0]      tcnt, tcnt_nxt;
    logic                 abort_pend, pend_nxt;
    logic [1:0]           status_nxt;
    logic                 done_nxt;

    ad9361_phase_timer #(
        .WIDTH     (PH_W),
        .RESET_VAL (STARTUP_DELAY - 1)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (ph_load_c),
        .load_val  (ph_val_c),
        .expired_c (ph_expired_c)
    );

    // Next-state, counters and status; completion outranks abort, abort outranks timeout.
    always_comb begin
        state_nxt  = state;
        len_nxt    = len_q;
        count_nxt  = sample_count;
        tcnt_nxt   = tcnt;
        pend_nxt   = abort_pend;
        status_nxt = status;
        done_nxt   = 1'b0;
        case (state)
            ST_STARTUP: begin
                if (ph_expired_c) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    len_nxt    = req_len;
                    count_nxt  = '0;
                    pend_nxt   = 1'b0;
                    status_nxt = STATUS_OK;
                    if (req_len == '0) done_nxt = 1'b1;
                    else               state_nxt = ST_EN_ON;
                end
            end
            ST_EN_ON: begin
                if (abort) pend_nxt = 1'b1;
                if (ph_expired_c) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort) pend_nxt = 1'b1;
                if (ph_expired_c) begin
                    state_nxt = ST_CAPTURE;
                    tcnt_nxt  = '0;
                end
            end
            ST_CAPTURE: begin
                tcnt_nxt = tcnt + TO_W'(1);
                if (abort_pend) begin
                    state_nxt  = ST_EN_OFF;
                    status_nxt = STATUS_ABORT;
                end else begin
                    if (sample_valid) count_nxt = sample_count + LEN_WIDTH'(1);
                    if (sample_valid && (sample_count + LEN_WIDTH'(1) == len_q)) begin
                        state_nxt  = ST_EN_OFF;
                        status_nxt = STATUS_OK;
                    end else if (abort) begin
                        state_nxt  = ST_EN_OFF;
                        status_nxt = STATUS_ABORT;
                    end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt  = ST_EN_OFF;
                        status_nxt = STATUS_TIMEOUT;
                    end
                end
            end
            ST_EN_OFF: begin
                if (ph_expired_c) state_nxt = ST_GUARD;
            end
            ST_GUARD: begin
                if (ph_expired_c) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_STARTUP;
        endcase
    end

    // Phase timer reloads on every state change with the new state's length minus one.
    always_comb begin
        ph_load_c = (state_nxt != state);
        ph_val_c  = '0;
        case (state_nxt)
            ST_STARTUP: ph_val_c = PH_W'(STARTUP_DELAY - 1);
            ST_EN_ON:   ph_val_c = PH_W'(ENABLE_CYCLES - 1);
            ST_SETTLE:  ph_val_c = PH_W'(SETTLE_CYCLES - 1);
            ST_EN_OFF:  ph_val_c = PH_W'(ENABLE_CYCLES - 1);
            ST_GUARD:   ph_val_c = PH_W'(ENABLE_CYCLES - 1);
            default:    ph_val_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_STARTUP;
            len_q        <= '0;
            tcnt         <= '0;
            abort_pend   <= 1'b0;
            sample_count <= '0;
            status       <= STATUS_OK;
            done         <= 1'b0;
            enable       <= 1'b0;
            capture_en   <= 1'b0;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
        end else begin
            state        <= state_nxt;
            len_q        <= len_nxt;
            tcnt         <= tcnt_nxt;
            abort_pend   <= pend_nxt;
            sample_count <= count_nxt;
            status       <= status_nxt;
            done         <= done_nxt;
            enable       <= (state_nxt == ST_EN_ON) || (state_nxt == ST_EN_OFF);
            capture_en   <= (state_nxt == ST_CAPTURE);
            req_ready    <= (state_nxt == ST_IDLE);
            busy         <= (state_nxt != ST_IDLE);
        end
    end

    assign txnrx = 1'b0;

endmodule

// File: tb/tb_ad9361_rx_burst_ctrl.sv
// Directed plus randomized bench for ad9361_rx_burst_ctrl against a burst-timeline reference model.
module tb_ad9361_rx_burst_ctrl;

    localparam int unsigned LW = 16;
    localparam int SD = 16;
    localparam int E  = 4;
    localparam int S  = 8;
    localparam int TO = 20;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_AB  = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [LW-1:0] req_len;
    logic          abort;
    logic          sample_valid;
    logic          enable;
    logic          txnrx;
    logic          capture_en;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic [LW-1:0] sample_count;

    int n_assert = 0;
    int n_fail   = 0;
    int cur_k    = 0;

    always #5 clk = ~clk;

    ad9361_rx_burst_ctrl #(
        .STARTUP_DELAY  (SD),
        .ENABLE_CYCLES  (E),
        .SETTLE_CYCLES  (S),
        .LEN_WIDTH      (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_len      (req_len),
        .abort        (abort),
        .sample_valid (sample_valid),
        .enable       (enable),
        .txnrx        (txnrx),
        .capture_en   (capture_en),
        .busy         (busy),
        .done         (done),
        .status       (status),
        .sample_count (sample_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, cur_k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected burst timeline: k counts cycles after the accepting cycle.
    task automatic run_burst(input int len, input logic [TO-1:0] pat, input int abort_at, input int pre_k);
        int n, cnt, cs, ce, k_end;
        logic [1:0] st;
        n = 0; cnt = 0; st = ST_OK;
        if (pre_k > 0) begin
            n = 1; st = ST_AB;
        end else begin
            for (int i = 0; i < TO; i++) begin
                n = i + 1;
                if (pat[i]) cnt++;
                if (pat[i] && cnt == len) begin st = ST_OK; break; end
                if (i == abort_at) begin st = ST_AB; break; end
                if (i == TO - 1) st = ST_TMO;
            end
        end
        cs    = E + S + 1;
        ce    = E + S + n;
        k_end = 3 * E + S + n + 1;

        req_valid    = 1'b1;
        req_len      = LW'(len);
        sample_valid = 1'($urandom_range(0, 1));
        abort        = 1'($urandom_range(0, 1));
        for (int k = 1; k <= k_end; k++) begin
            step();
            cur_k = k;
            chk("enable", enable, (k >= 1 && k <= E) || (k > ce && k <= ce + E));
            chk("capture_en", capture_en, k >= cs && k <= ce);
            chk("busy", busy, k < k_end);
            chk("req_ready", req_ready, k == k_end);
            chk("done", done, k == k_end);
            chk("txnrx", txnrx, 0);
            if (k == 1) chk("count_clear", sample_count, 0);
            if (k == k_end) begin
                chk("sample_count", sample_count, cnt);
                chk("status", status, st);
            end
            req_valid    = (k < k_end) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_len      = LW'($urandom);
            sample_valid = (k >= cs && k <= ce) ? pat[k - cs] : 1'($urandom_range(0, 1));
            abort        = (k == pre_k) ||
                           (abort_at >= 0 && abort_at < n && k == cs + abort_at) ||
                           (k > ce && k < k_end && $urandom_range(0, 3) == 0);
        end
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_len = '0; abort = 1'b0; sample_valid = 1'b0;
        step();
        step();
        chk("rst_enable", enable, 0);
        chk("rst_capture_en", capture_en, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 1);
        chk("rst_status", status, 0);
        chk("rst_count", sample_count, 0);
        chk("rst_txnrx", txnrx, 0);

        // Startup with req_valid held high and a zero-length request.
        rst = 1'b0; req_valid = 1'b1; req_len = '0;
        for (int k = 1; k <= SD + 1; k++) begin
            step();
            cur_k = k;
            chk("su_req_ready", req_ready, k >= SD);
            chk("su_enable", enable, 0);
            chk("su_busy", busy, k < SD);
            chk("su_done", done, k == SD + 1);
        end
        chk("zl_status", status, ST_OK);
        chk("zl_count", sample_count, 0);
        req_valid = 1'b0;
        step();
        chk("zl_done_once", done, 0);
        chk("zl_idle_ready", req_ready, 1);

        run_burst(5, 20'h55555, -1, 0);          // every other cycle, completes
        run_burst(10, 20'h55555, 5, 0);          // abort after 3 samples
        run_burst(10, 20'hFFFFF, -1, 8);         // abort latched in SETTLE
        run_burst(5, 20'h00000, -1, 0);          // timeout with no samples
        run_burst(3, 20'h55555, 4, 0);           // abort coincident with final sample
        run_burst(65535, 20'hFFFFF, -1, 0);      // maximum length, timeout keeps count
        run_burst(1, 20'h00008, -1, 2);          // abort latched in EN_ON

        for (int r = 0; r < 14; r++) begin
            int mode;
            mode = $urandom_range(0, 3);
            if (mode == 0)      run_burst($urandom_range(1, 25), TO'($urandom), -1, $urandom_range(1, E + S));
            else if (mode == 1) run_burst($urandom_range(1, 25), TO'($urandom), $urandom_range(0, TO - 1), 0);
            else                run_burst($urandom_range(1, 25), TO'($urandom), -1, 0);
            repeat ($urandom_range(0, 2)) begin
                step();
                chk("idle_done", done, 0);
                chk("idle_ready", req_ready, 1);
            end
        end

        // Asynchronous reset in the middle of CAPTURE.
        req_valid = 1'b1; req_len = 16'd8; sample_valid = 1'b1; abort = 1'b0;
        step();
        req_valid = 1'b0;
        repeat (E + S + 1) step();
        chk("pre_rst_capture", capture_en, 1);
        chk("pre_rst_count", sample_count, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_enable", enable, 0);
        chk("arst_capture_en", capture_en, 0);
        chk("arst_busy", busy, 1);
        chk("arst_count", sample_count, 0);
        chk("arst_req_ready", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        sample_valid = 1'b0;
        for (int k = 1; k <= SD; k++) begin
            step();
            cur_k = k;
            chk("rs_req_ready", req_ready, k == SD);
            chk("rs_enable", enable, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
